delta_decoder: RTL

Reconstructs a WIDTH-bit sample stream from the 2-bit spike codes produced by the delta-modulation encoder, forming the receive end of the spike link. Incoming codes are buffered in a small FIFO, applied to a saturating reconstruction accumulator, and presented on a valid/ready output port. The block also reports a spike count, a saturation flag and an illegal-code flag for debug readout.

---
 rtl/delta_pkg.sv | 18 +
 rtl/spike_fifo.sv | 65 ++++++
 rtl/delta_decoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/delta_pkg.sv
// Shared definitions for the delta-modulation spike link (encoder and decoder).
// Contents: spike code constants, the decoder state enum, and the default sample width.
package delta_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  // Code bit0 = spike event, bit1 = direction (1 = down).
  localparam logic [1:0] SPK_NONE    = 2'b00;
  localparam logic [1:0] SPK_UP      = 2'b01;
  localparam logic [1:0] SPK_ILLEGAL = 2'b10;
  localparam logic [1:0] SPK_DOWN    = 2'b11;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/spike_fifo.sv
// DEPTH x 2-bit synchronous FIFO (registered, not fall-through) for incoming spike codes.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_flush          empties the FIFO (has priority over push/pop)
//   i_push, i_data   write a code
//   i_pop, o_data    o_data is the head entry; i_pop advances it
//   o_count          number of stored entries
//   o_full, o_empty  status
module spike_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [1:0]                 i_data,
  input  logic                       i_pop,
  output logic [1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/delta_decoder.sv
// Delta-modulation decoder: buffers 2-bit spike codes, applies them to a saturating
// reconstruction accumulator, and presents samples on a valid/ready port.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   init_load, init_data     seed accumulator, flush pipeline, clear debug state
//   threshold                encoder threshold; step = threshold + 1 at pop time
//   in_valid/in_ready/spike  code input handshake
//   out_valid/out_ready      sample output handshake, data_out = sample
//   spike_count              up/down codes applied (wraps)
//   sat_flag, err_flag       sticky clamp / illegal-code flags
module delta_decoder #(
  parameter int unsigned WIDTH = delta_pkg::DEFAULT_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_load,
  input  logic [WIDTH-1:0] init_data,
  input  logic [WIDTH-1:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       spike,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [7:0]       spike_count,
  output logic             sat_flag,
  output logic             err_flag
);

  import delta_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic [7:0]       r_spike_count;
  logic             r_sat_flag;
  logic             r_err_flag;

  logic             w_run;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic [WIDTH:0]   w_step;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_sat;
  logic             w_err;
  logic             w_counted;

  assign w_run    = (r_state == RUN);
  assign in_ready = w_run && !w_full;
  // init_load wins: a same-cycle write or pop is discarded along with the flush.
  assign w_push   = in_valid && in_ready && !init_load;
  assign w_pop    = w_run && !w_empty && (!r_out_valid || out_ready) && !init_load;

  spike_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (init_load),
    .i_push  (w_push),
    .i_data  (spike),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // One extra bit holds both the full step range and the up-carry / down-borrow.
  assign w_step = {1'b0, threshold} + (WIDTH + 1)'(1);
  assign w_sum  = {1'b0, r_acc} + w_step;
  assign w_diff = {1'b0, r_acc} - w_step;

  always_comb begin
    w_acc_next = r_acc;
    w_sat      = 1'b0;
    w_err      = 1'b0;
    w_counted  = 1'b0;
    unique case (w_head)
      SPK_UP: begin
        w_counted = 1'b1;
        if (w_sum[WIDTH]) begin
          w_acc_next = '1;
          w_sat      = 1'b1;
        end else begin
          w_acc_next = w_sum[WIDTH-1:0];
        end
      end
      SPK_DOWN: begin
        w_counted = 1'b1;
        if (w_diff[WIDTH]) begin
          w_acc_next = '0;
          w_sat      = 1'b1;
        end else begin
          w_acc_next = w_diff[WIDTH-1:0];
        end
      end
      SPK_ILLEGAL: w_err = 1'b1;
      SPK_NONE:    w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= INIT;
      r_acc         <= '0;
      r_data_out    <= '0;
      r_out_valid   <= 1'b0;
      r_spike_count <= '0;
      r_sat_flag    <= 1'b0;
      r_err_flag    <= 1'b0;
    end else if (init_load) begin
      r_state       <= RUN;
      r_acc         <= init_data;
      r_out_valid   <= 1'b0;
      r_spike_count <= '0;
      r_sat_flag    <= 1'b0;
      r_err_flag    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_pop) begin
            r_acc       <= w_acc_next;
            r_data_out  <= w_acc_next;
            r_out_valid <= 1'b1;
            if (w_counted) r_spike_count <= r_spike_count + 8'd1;
            if (w_sat)     r_sat_flag    <= 1'b1;
            if (w_err)     r_err_flag    <= 1'b1;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign data_out    = r_data_out;
  assign spike_count = r_spike_count;
  assign sat_flag    = r_sat_flag;
  assign err_flag    = r_err_flag;

endmodule
